divider_scheduler: RTL and testbench
====================================

// Module: divider_scheduler
// PURPOSE
//  Round-robin scheduler that shares one programmable divide counter among NUM_REQ requesters.
//  Each granted requester supplies a divide value and a half-period count.
//  The block toggles outclk every (div_val+1) clk cycles until that many toggles are done.
//  It then pulses done to the owner and re-arbitrates.
//  Sits between the control FSMs and the shared slow-clock/tick path.
// PARAMETERS
//  NUM_REQ  4   number of requesters (2..8)
//  CNT_W    28  divide counter / divide value width
//  HP_W     8   half-period count width
// PORTS
//  clk        in   1                clock
//  reset_n    in   1                asynchronous, active-low reset
//  req        in   NUM_REQ          per-requester level request; hold high until done
//  div_val    in   NUM_REQ*CNT_W    requester i at [i*CNT_W +: CNT_W]
//  n_half     in   NUM_REQ*HP_W     requester i at [i*HP_W +: HP_W]; number of outclk toggles
//  gnt        out  NUM_REQ          one-hot grant, registered
//  done       out  NUM_REQ          one-cycle completion pulse to owner, registered
//  busy       out  1                high whenever state != IDLE
//  owner      out  $clog2(NUM_REQ)  index of current or last owner
//  outclk     out  1                shared divided output, registered
// BEHAVIOUR
//  Reset:
//  - reset_n=0 forces all regs immediately: state=IDLE, gnt=0, done=0, outclk=0, owner=0.
//  - Also clears counter=0, tog_cnt=0 and RR pointer ptr=0.
//  - Reset mid-run aborts silently; no done pulse is issued.
//  FSM states: IDLE, RUN, DONE.
//  IDLE:
//  - If req!=0, the winner w is the first set bit scanning ptr, ptr+1, ... with modulo NUM_REQ wrap.
//  - At the clock edge: gnt[w]<=1, owner<=w, latch div_val[w] and n_half[w] into div_lat and hp_lat.
//  - At the same edge: counter<=0, tog_cnt<=0.
//  - Next state is RUN, or DONE if n_half[w]==0.
//  - Latency from req sampled high to gnt high is 1 cycle.
//  - Inputs are sampled only at grant. Later changes to div_val/n_half are ignored until the next grant.
//  RUN (evaluated in this order):
//  - Abort: if req[owner]==0, then gnt<=0, outclk<=0, ptr<=owner+1 (mod NUM_REQ), next state IDLE, no done.
//  - Count: else if counter!=div_lat, counter<=counter+1.
//  - Toggle: else counter<=0, outclk<=~outclk, tog_cnt<=tog_cnt+1.
//  - If tog_cnt+1==hp_lat on a toggle, next state is DONE.
//  - Exactly hp_lat toggles occur, each (div_lat+1) cycles apart.
//  - RUN lasts hp_lat*(div_lat+1) cycles.
//  - div_lat==0 gives a toggle every cycle. div_lat==all-ones must not overflow counter.
//  DONE (exactly 1 cycle):
//  - done[owner]=1 and gnt[owner] is still 1 during this cycle.
//  - At the exit edge: done<=0, gnt<=0, outclk<=0, ptr<=owner+1 (mod NUM_REQ), next state IDLE.
//  - Total gnt high time is hp_lat*(div_lat+1)+1 cycles. There is always at least 1 IDLE cycle between grants.
//  Fairness:
//  - The just-served requester has lowest priority next time.
//  - A req still high in the IDLE cycle after done counts as a new request.
//  Other rules:
//  - done is never asserted without a preceding gnt.
//  - gnt and done are always one-hot or zero.
//  - busy == (state!=IDLE), combinational from the state register.
// TESTING
//  1. Single run: req[0]=1, div_val0=2, n_half0=4.
//     -> gnt[0] 1 cycle after req; outclk toggles at RUN cycles 3, 6, 9, 12 (ends 0).
//     -> done[0] in the next cycle; gnt high for 13 cycles.
//  2. Round robin: req=4'b0011 held continuously with each grant completing.
//     -> grant order 0, 1, 0, 1; 1 IDLE cycle between grants; never two gnt bits high.
//  3. Abort: req[2] dropped after 5 RUN cycles (div_val=9, n_half=3).
//     -> gnt=0 and outclk=0 next cycle; done stays 0; next grant scan starts at 3.
//  4. Edge values: n_half=0 -> IDLE->DONE directly, no outclk toggle, gnt high 1 cycle.
//     div_val=0, n_half=5 -> 5 consecutive toggles, outclk ends 1 then forced 0.
//  5. Reset mid-run: reset_n low during RUN (div_val=100).
//     -> gnt, done, outclk and busy are 0 immediately (async), with no done.
//     -> After release with req[3]=1, ptr=0 and requester 3 is granted.
//  6. Input change during run: change div_val0 from 2 to 7 mid-RUN -> toggle spacing stays 3 cycles.

Source files
------------

// File: rtl/divider_scheduler.sv
// divider_scheduler: round-robin arbiter sharing one programmable divide
// counter among NUM_REQ requesters. The granted requester's divide value and
// half-period count are latched at grant; outclk toggles every (div_lat+1)
// cycles until hp_lat toggles are done, then done pulses to the owner.
//
// state | meaning
// IDLE  | no owner; scan requests from ptr and grant the first one found
// RUN   | owner holds the counter; count, toggle outclk, or abort on req drop
// DONE  | single cycle with done[owner] and gnt[owner] both high
module divider_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 28,
    parameter int HP_W    = 8,
    localparam int OW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] div_val,
    input  logic [NUM_REQ*HP_W-1:0]  n_half,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [OW-1:0]            owner,
    output logic                     outclk
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    state_t             state;
    state_t             state_nxt;
    logic [OW-1:0]      ptr;
    logic [OW-1:0]      ptr_nxt;
    logic [CNT_W-1:0]   div_lat;
    logic [HP_W-1:0]    hp_lat;
    logic [CNT_W-1:0]   counter;
    logic [HP_W-1:0]    tog_cnt;
    logic               win_found;
    logic [OW-1:0]      win_idx;
    logic [CNT_W-1:0]   div_sel;
    logic [HP_W-1:0]    hp_sel;
    logic               cnt_hit;
    logic               last_tog;
    logic               req_own;

    // Round-robin scan: first set request starting at ptr, wrapping modulo NUM_REQ
    always_comb begin
        int unsigned idx;
        win_found = 1'b0;
        win_idx   = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_idx   = OW'(idx);
            end
        end
    end

    assign div_sel  = div_val[win_idx*CNT_W +: CNT_W];
    assign hp_sel   = n_half[win_idx*HP_W +: HP_W];
    // counter never passes div_lat, so an all-ones divide value cannot wrap it
    assign cnt_hit  = (counter == div_lat);
    assign last_tog = ((tog_cnt + HP_W'(1)) == hp_lat);
    assign req_own  = req[owner];
    assign ptr_nxt  = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode; abort takes priority over counting in RUN
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (win_found) state_nxt = (hp_sel == '0) ? DONE : RUN;
            RUN: begin
                if (!req_own)                state_nxt = IDLE;
                else if (cnt_hit && last_tog) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status output derived from the state register
    always_comb begin
        busy = (state != IDLE);
    end

    // Registered grant/done/outclk, latched request parameters and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gnt     <= '0;
            done    <= '0;
            outclk  <= 1'b0;
            owner   <= '0;
            ptr     <= '0;
            div_lat <= '0;
            hp_lat  <= '0;
            counter <= '0;
            tog_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (win_found) begin
                        gnt     <= ONE_HOT0 << win_idx;
                        owner   <= win_idx;
                        div_lat <= div_sel;
                        hp_lat  <= hp_sel;
                        counter <= '0;
                        tog_cnt <= '0;
                        // zero toggles requested: done rises together with gnt
                        if (hp_sel == '0) done <= ONE_HOT0 << win_idx;
                    end
                end
                RUN: begin
                    if (!req_own) begin
                        gnt    <= '0;
                        outclk <= 1'b0;
                        ptr    <= ptr_nxt;
                    end else if (!cnt_hit) begin
                        counter <= counter + 1'b1;
                    end else begin
                        counter <= '0;
                        outclk  <= ~outclk;
                        tog_cnt <= tog_cnt + 1'b1;
                        if (last_tog) done <= ONE_HOT0 << owner;
                    end
                end
                DONE: begin
                    done   <= '0;
                    gnt    <= '0;
                    outclk <= 1'b0;
                    ptr    <= ptr_nxt;
                end
                default: begin
                    done   <= '0;
                    gnt    <= '0;
                    outclk <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_scheduler.sv
// Bench for divider_scheduler: a monitor measures every grant (owner, length,
// toggle positions, done) and compares against expectations queued by stimulus.
module tb_divider_scheduler;

    localparam int NR = 4;
    localparam int CW = 28;
    localparam int HW = 8;

    logic              clk;
    logic              reset_n;
    logic [NR-1:0]     req;
    logic [NR*CW-1:0]  div_val;
    logic [NR*HW-1:0]  n_half;
    logic [NR-1:0]     gnt;
    logic [NR-1:0]     done;
    logic              busy;
    logic [1:0]        owner;
    logic              outclk;

    typedef struct {
        int own;
        int len;
        int togs;
        int spacing;
        int last_oc;
        int done;
        int gap;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    divider_scheduler #(.NUM_REQ(NR), .CNT_W(CW), .HP_W(HW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .div_val (div_val),
        .n_half  (n_half),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .owner   (owner),
        .outclk  (outclk)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int own, input int dv, input int nh, input int gap);
        exp_t e;
        e.own     = own;
        e.len     = nh * (dv + 1) + 1;
        e.togs    = nh;
        e.spacing = dv + 1;
        e.last_oc = nh % 2;
        e.done    = 1;
        e.gap     = gap;
        return e;
    endfunction

    task automatic set_cfg(input int i, input int dv, input int nh);
        div_val[i*CW +: CW] = CW'(dv);
        n_half[i*HW +: HW]  = HW'(nh);
    endtask

    task automatic wait_gnt(input int i, output int lat);
        lat = 0;
        while (!gnt[i] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!gnt[i]) chk("gnt_timeout", 0, 1);
    endtask

    // Wait for n done pulses; optionally drop the finished requests and
    // rewrite one divide value chg_at cycles in.
    task automatic wait_dones(input int n, input bit drop, input int chg_at,
                              input int chg_idx, input int chg_dv);
        int seen = 0;
        int cyc  = 0;
        while (1) begin
            if (done != '0) begin
                seen++;
                if (drop) req = req & ~done;
            end
            if (seen >= n || cyc >= 5000) break;
            @(negedge clk);
            cyc++;
            if (chg_at > 0 && cyc == chg_at) div_val[chg_idx*CW +: CW] = CW'(chg_dv);
        end
        if (seen < n) chk("done_timeout", seen, n);
    endtask

    // Monitor: measures each grant window and checks it against the scoreboard
    initial begin
        bit   in_run = 0;
        int   cur_own = 0, len = 0, togs = 0, done_seen = 0, done_bad = 0;
        int   last_oc = 0, idle_cnt = -1, gap_at_start = -1;
        logic prev_oc = 1'b0;
        int   tpos[$];
        exp_t e;
        bit   ok;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_run   = 0;
                idle_cnt = -1;
            end else if (gnt != '0) begin
                if (!in_run) begin
                    in_run = 1;
                    for (int b = 0; b < NR; b++) if (gnt[b]) cur_own = b;
                    len = 0; togs = 0; done_seen = 0; done_bad = 0; last_oc = 0;
                    tpos.delete();
                    gap_at_start = idle_cnt;
                    chk("gnt_onehot", $onehot(gnt), 1);
                end
                len++;
                if (outclk != prev_oc) begin
                    togs++;
                    tpos.push_back(len);
                end
                if (done != '0) begin
                    done_seen++;
                    if (done != gnt) done_bad = 1;
                end
                last_oc = int'(outclk);
            end else begin
                if (done != '0) chk("done_without_gnt", done, 0);
                if (in_run) begin
                    in_run   = 0;
                    idle_cnt = 0;
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("owner_idx", cur_own, e.own);
                        chk("gnt_len", len, e.len);
                        chk("toggle_count", togs, e.togs);
                        chk("done_count", done_seen, e.done);
                        chk("done_matches_gnt", done_bad, 0);
                        chk("outclk_last", last_oc, e.last_oc);
                        chk("outclk_cleared", outclk, 0);
                        ok = 1;
                        for (int k = 0; k < tpos.size(); k++)
                            if (tpos[k] != (k + 1) * e.spacing + 1) ok = 0;
                        chk("toggle_spacing", ok, 1);
                        if (e.gap >= 0) chk("idle_gap", gap_at_start, e.gap);
                    end
                end
                if (idle_cnt >= 0) idle_cnt++;
            end
            prev_oc = outclk;
        end
    end

    initial begin
        int   lat;
        exp_t e;
        reset_n = 1'b0;
        req     = '0;
        div_val = '0;
        n_half  = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_outclk", outclk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // round robin between 0 and 1, requests held throughout
        set_cfg(0, 1, 2);
        set_cfg(1, 1, 2);
        sb.push_back(mk(0, 1, 2, -1));
        sb.push_back(mk(1, 1, 2, 1));
        sb.push_back(mk(0, 1, 2, 1));
        sb.push_back(mk(1, 1, 2, 1));
        req = 4'b0011;
        wait_dones(4, 0, 0, 0, 0);
        req = 4'b0000;
        repeat (3) @(negedge clk);

        // single run div 2, 4 half periods
        set_cfg(0, 2, 4);
        sb.push_back(mk(0, 2, 4, -1));
        req[0] = 1'b1;
        wait_gnt(0, lat);
        chk("gnt_latency_t1", lat, 1);
        wait_dones(1, 1, 0, 0, 0);
        repeat (2) @(negedge clk);

        // divide value rewritten mid-run must be ignored
        set_cfg(0, 2, 4);
        sb.push_back(mk(0, 2, 4, -1));
        req[0] = 1'b1;
        wait_gnt(0, lat);
        chk("gnt_latency_t6", lat, 1);
        wait_dones(1, 1, 4, 0, 7);
        repeat (2) @(negedge clk);

        // zero half periods: straight to DONE
        set_cfg(1, 5, 0);
        sb.push_back(mk(1, 5, 0, -1));
        req[1] = 1'b1;
        wait_gnt(1, lat);
        chk("gnt_latency_nh0", lat, 1);
        wait_dones(1, 1, 0, 0, 0);
        repeat (2) @(negedge clk);

        // divide by one: toggle every cycle
        set_cfg(3, 0, 5);
        sb.push_back(mk(3, 0, 5, -1));
        req[3] = 1'b1;
        wait_gnt(3, lat);
        wait_dones(1, 1, 0, 0, 0);
        repeat (2) @(negedge clk);

        // abort: requester 2 drops after 5 RUN cycles
        set_cfg(2, 9, 3);
        e = mk(2, 9, 3, -1);
        e.len = 6; e.togs = 0; e.last_oc = 0; e.done = 0;
        sb.push_back(e);
        req[2] = 1'b1;
        wait_gnt(2, lat);
        chk("gnt_latency_abort", lat, 1);
        repeat (5) @(negedge clk);
        req[2] = 1'b0;
        @(negedge clk);
        chk("abort_gnt", gnt, 0);
        chk("abort_outclk", outclk, 0);
        chk("abort_done", done, 0);
        // scan must now start at 3, ahead of 2
        set_cfg(2, 0, 1);
        set_cfg(3, 0, 1);
        sb.push_back(mk(3, 0, 1, -1));
        sb.push_back(mk(2, 0, 1, 1));
        req = 4'b1100;
        wait_dones(2, 1, 0, 0, 0);
        repeat (2) @(negedge clk);

        // asynchronous reset in the middle of a long run
        set_cfg(0, 100, 2);
        req = 4'b0001;
        wait_gnt(0, lat);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_gnt", gnt, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_outclk", outclk, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_owner", owner, 0);
        req = 4'b1010;
        set_cfg(1, 1, 1);
        set_cfg(3, 1, 1);
        sb.push_back(mk(1, 1, 1, -1));
        sb.push_back(mk(3, 1, 1, 1));
        @(negedge clk);
        reset_n = 1'b1;
        wait_dones(2, 1, 0, 0, 0);
        repeat (5) @(negedge clk);

        chk("sb_drained", sb.size(), 0);
        chk("final_busy", busy, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
